// File: rtl/kmkz_writeback_pkg.sv
// kmkz_writeback_pkg
//   Shared encodings for the Kamikaze-uRV writeback stage: load/store size
//   codes (funct3), destination-value source selects, writeback FSM states
//   and the layout of a retired register-file write.
package kmkz_writeback_pkg;

    // funct3 load/store sizes; bit 2 set means zero-extend
    localparam logic [2:0] LDST_B  = 3'd0;
    localparam logic [2:0] LDST_H  = 3'd1;
    localparam logic [2:0] LDST_L  = 3'd2;
    localparam logic [2:0] LDST_BU = 3'd4;
    localparam logic [2:0] LDST_HU = 3'd5;

    localparam logic [1:0] RD_SOURCE_ALU      = 2'd0;
    localparam logic [1:0] RD_SOURCE_SHIFTER  = 2'd1;
    localparam logic [1:0] RD_SOURCE_MULTIPLY = 2'd2;
    localparam logic [1:0] RD_SOURCE_CSR      = 2'd3;

    // IDLE: no data phase outstanding / completing on the bus
    // WAIT: data phase wait-stated by the slave
    // HELD: data phase finished under a pipeline stall; bus result captured
    typedef enum logic [1:0] {
        WB_IDLE = 2'd0,
        WB_WAIT = 2'd1,
        WB_HELD = 2'd2
    } wb_state_t;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] value;
        logic        write;
    } wb_write_t;

endpackage

// File: rtl/kmkz_load_align.sv
// kmkz_load_align
//   Combinational load-data alignment: picks the byte/halfword lane addressed
//   by the low address bits and sign- or zero-extends it to 32 bits.
//   i_fun   : funct3 load size/sign
//   i_off   : byte offset within the word (address[1:0])
//   i_data  : raw 32-bit bus read data
//   o_value : aligned, extended load result
module kmkz_load_align
    import kmkz_writeback_pkg::*;
(
    input  logic [2:0]  i_fun,
    input  logic [1:0]  i_off,
    input  logic [31:0] i_data,
    output logic [31:0] o_value
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = i_data[7:0];
        case (i_off)
            2'd1:    w_byte = i_data[15:8];
            2'd2:    w_byte = i_data[23:16];
            2'd3:    w_byte = i_data[31:24];
            default: w_byte = i_data[7:0];
        endcase
    end

    // halfword lane is chosen by off[1]; off[0] is assumed zero
    assign w_half = i_off[1] ? i_data[31:16] : i_data[15:0];

    always_comb begin
        o_value = i_data;
        case (i_fun)
            LDST_B:  o_value = {{24{w_byte[7]}}, w_byte};
            LDST_BU: o_value = {24'd0, w_byte};
            LDST_H:  o_value = {{16{w_half[15]}}, w_half};
            LDST_HU: o_value = {16'd0, w_half};
            default: o_value = i_data;
        endcase
    end

endmodule

// File: rtl/kmkz_writeback.sv
// kmkz_writeback
//   Writeback stage: completes the AHB-Lite data phase of loads/stores,
//   aligns load data, selects the destination value and drives the
//   register-file write port. Keeps a registered copy of the last retired
//   write for bypassing and a sticky bus-error flag.
//   clk_i/rst_i          : clock, synchronous active-low reset
//   w_stall_i            : pipeline stall, blocks retirement
//   w_stall_req_o        : data phase is wait-stated
//   x_*                  : registered outputs of the execute stage
//   HRDATA/HREADY/HRESP  : AHB data-phase response
//   rf_rd_*              : register-file write port (combinational)
//   w_bypass_rd_*        : last retired write, registered
//   w_bus_error_o        : sticky, set by any data phase answered with HRESP=1
module kmkz_writeback
    import kmkz_writeback_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        w_stall_i,
    output logic        w_stall_req_o,
    input  logic [2:0]  x_fun_i,
    input  logic        x_load_i,
    input  logic        x_store_i,
    input  logic        x_valid_i,
    input  logic [4:0]  x_rd_i,
    input  logic        x_rd_write_i,
    input  logic [31:0] x_rd_value_i,
    input  logic [1:0]  x_rd_source_i,
    input  logic [31:0] x_shifter_rd_value_i,
    input  logic [31:0] x_multiply_rd_value_i,
    input  logic [31:0] x_dm_addr_i,
    input  logic [31:0] HRDATA,
    input  logic        HREADY,
    input  logic        HRESP,
    output logic [4:0]  rf_rd_o,
    output logic [31:0] rf_rd_value_o,
    output logic        rf_rd_write_o,
    output logic [4:0]  w_bypass_rd_o,
    output logic [31:0] w_bypass_rd_value_o,
    output logic        w_bypass_rd_write_o,
    output logic        w_bus_error_o
);

    wb_state_t   r_state, w_state_nxt;
    logic [31:0] r_hrdata;
    logic        r_hresp;
    logic        r_bus_error;
    wb_write_t   r_bypass;

    logic        w_mem, w_held, w_resp, w_phase_done, w_retire, w_load_err;
    logic [31:0] w_rdata, w_load_value, w_rd_value;
    logic        w_unused_addr;

    // exec guarantees natural alignment, so only the lane bits matter
    assign w_unused_addr = &{1'b0, x_dm_addr_i[31:2]};

    assign w_mem  = (x_load_i | x_store_i) & x_valid_i;
    assign w_held = (r_state == WB_HELD);

    // once HELD, the bus has moved on: use the captured response
    assign w_rdata = w_held ? r_hrdata : HRDATA;
    assign w_resp  = w_held ? r_hresp  : HRESP;

    // data phase finishing on the bus this very cycle
    assign w_phase_done = w_mem & ~w_held & HREADY;

    assign w_retire = rst_i & x_valid_i & ~w_stall_i & (~w_mem | w_held | HREADY);

    assign w_load_err = x_load_i & w_resp;

    assign w_stall_req_o = w_mem & ~HREADY & ~w_held;

    kmkz_load_align u_align (
        .i_fun   (x_fun_i),
        .i_off   (x_dm_addr_i[1:0]),
        .i_data  (w_rdata),
        .o_value (w_load_value)
    );

    always_comb begin
        w_rd_value = x_rd_value_i;
        if (x_load_i) begin
            w_rd_value = w_load_value;
        end else begin
            case (x_rd_source_i)
                RD_SOURCE_SHIFTER:  w_rd_value = x_shifter_rd_value_i;
                RD_SOURCE_MULTIPLY: w_rd_value = x_multiply_rd_value_i;
                default:            w_rd_value = x_rd_value_i;
            endcase
        end
    end

    assign rf_rd_o       = x_rd_i;
    assign rf_rd_value_o = w_rd_value;
    assign rf_rd_write_o = w_retire & x_rd_write_i & ~x_store_i &
                           (x_rd_i != 5'd0) & ~w_load_err;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            WB_IDLE, WB_WAIT: begin
                if (!w_mem)        w_state_nxt = WB_IDLE;
                else if (!HREADY)  w_state_nxt = WB_WAIT;
                else if (w_stall_i) w_state_nxt = WB_HELD;
                else               w_state_nxt = WB_IDLE;
            end
            WB_HELD: begin
                if (!w_stall_i) w_state_nxt = WB_IDLE;
            end
            default: w_state_nxt = WB_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_state     <= WB_IDLE;
            r_hrdata    <= 32'd0;
            r_hresp     <= 1'b0;
            r_bus_error <= 1'b0;
            r_bypass    <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_phase_done && w_stall_i) begin
                r_hrdata <= HRDATA;
                r_hresp  <= HRESP;
            end
            if (w_phase_done && HRESP)
                r_bus_error <= 1'b1;
            if (w_retire)
                r_bypass <= '{rd: rf_rd_o, value: rf_rd_value_o, write: rf_rd_write_o};
        end
    end

    assign w_bypass_rd_o       = r_bypass.rd;
    assign w_bypass_rd_value_o = r_bypass.value;
    assign w_bypass_rd_write_o = r_bypass.write;
    assign w_bus_error_o       = r_bus_error;

endmodule

// File: tb/tb_kmkz_writeback.sv
// tb_kmkz_writeback
//   Directed bench for kmkz_writeback. A behavioural model (outstanding data
//   phase held or not, sticky error, last retired write) is compared to the
//   DUT on every falling edge; literal expectations pin the key cases.
module tb_kmkz_writeback;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        w_stall_i;
    logic        w_stall_req_o;
    logic [2:0]  x_fun_i;
    logic        x_load_i, x_store_i, x_valid_i;
    logic [4:0]  x_rd_i;
    logic        x_rd_write_i;
    logic [31:0] x_rd_value_i;
    logic [1:0]  x_rd_source_i;
    logic [31:0] x_shifter_rd_value_i, x_multiply_rd_value_i;
    logic [31:0] x_dm_addr_i;
    logic [31:0] HRDATA;
    logic        HREADY, HRESP;
    logic [4:0]  rf_rd_o;
    logic [31:0] rf_rd_value_o;
    logic        rf_rd_write_o;
    logic [4:0]  w_bypass_rd_o;
    logic [31:0] w_bypass_rd_value_o;
    logic        w_bypass_rd_write_o;
    logic        w_bus_error_o;

    always #5 clk_i = ~clk_i;

    kmkz_writeback dut (
        .clk_i                 (clk_i),
        .rst_i                 (rst_i),
        .w_stall_i             (w_stall_i),
        .w_stall_req_o         (w_stall_req_o),
        .x_fun_i               (x_fun_i),
        .x_load_i              (x_load_i),
        .x_store_i             (x_store_i),
        .x_valid_i             (x_valid_i),
        .x_rd_i                (x_rd_i),
        .x_rd_write_i          (x_rd_write_i),
        .x_rd_value_i          (x_rd_value_i),
        .x_rd_source_i         (x_rd_source_i),
        .x_shifter_rd_value_i  (x_shifter_rd_value_i),
        .x_multiply_rd_value_i (x_multiply_rd_value_i),
        .x_dm_addr_i           (x_dm_addr_i),
        .HRDATA                (HRDATA),
        .HREADY                (HREADY),
        .HRESP                 (HRESP),
        .rf_rd_o               (rf_rd_o),
        .rf_rd_value_o         (rf_rd_value_o),
        .rf_rd_write_o         (rf_rd_write_o),
        .w_bypass_rd_o         (w_bypass_rd_o),
        .w_bypass_rd_value_o   (w_bypass_rd_value_o),
        .w_bypass_rd_write_o   (w_bypass_rd_write_o),
        .w_bus_error_o         (w_bus_error_o)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // load result from the word, offset and funct3, by shifting
    function automatic logic [31:0] ld_val(input logic [2:0] fun, input logic [1:0] off,
                                           input logic [31:0] d);
        logic [31:0] b, h;
        b = d >> (8 * off);
        h = d >> (16 * off[1]);
        case (fun)
            3'd0:    return 32'($signed(b[7:0]));
            3'd4:    return b & 32'h0000_00FF;
            3'd1:    return 32'($signed(h[15:0]));
            3'd5:    return h & 32'h0000_FFFF;
            default: return d;
        endcase
    endfunction

    // ---------------- model ----------------
    logic        m_held, m_hresp, m_err, m_bwr;
    logic [31:0] m_hdata, m_bval;
    logic [4:0]  m_brd;
    logic [31:0] e_d, e_val;
    logic        e_rsp, e_mem, e_ret, e_wr;

    initial begin
        m_held = 0; m_hresp = 0; m_err = 0; m_bwr = 0;
        m_hdata = 0; m_bval = 0; m_brd = 0;
    end

    always @(negedge clk_i) begin
        e_mem = (x_load_i || x_store_i) && x_valid_i;
        e_d   = m_held ? m_hdata : HRDATA;
        e_rsp = m_held ? m_hresp : HRESP;
        if (x_load_i)                   e_val = ld_val(x_fun_i, x_dm_addr_i[1:0], e_d);
        else if (x_rd_source_i == 2'd1) e_val = x_shifter_rd_value_i;
        else if (x_rd_source_i == 2'd2) e_val = x_multiply_rd_value_i;
        else                            e_val = x_rd_value_i;
        e_ret = rst_i && x_valid_i && !w_stall_i && (!e_mem || m_held || HREADY);
        e_wr  = e_ret && x_rd_write_i && !x_store_i && (x_rd_i != 0) && !(x_load_i && e_rsp);

        chk("m_rf_write",   rf_rd_write_o, e_wr);
        chk("m_stall_req",  w_stall_req_o, e_mem && !HREADY && !m_held);
        chk("m_byp_rd",     w_bypass_rd_o, m_brd);
        chk("m_byp_value",  w_bypass_rd_value_o, m_bval);
        chk("m_byp_write",  w_bypass_rd_write_o, m_bwr);
        chk("m_bus_error",  w_bus_error_o, m_err);
        if (e_wr) begin
            chk("m_rf_rd",    rf_rd_o, x_rd_i);
            chk("m_rf_value", rf_rd_value_o, e_val);
        end

        // advance to the state after the coming rising edge
        if (!rst_i) begin
            m_held = 0; m_hresp = 0; m_hdata = 0; m_err = 0;
            m_brd = 0; m_bval = 0; m_bwr = 0;
        end else begin
            if (e_ret) begin
                m_brd = x_rd_i; m_bval = e_val; m_bwr = e_wr;
            end
            if (e_mem && !m_held && HREADY) begin
                if (HRESP) m_err = 1;
                if (w_stall_i) begin
                    m_held = 1; m_hdata = HRDATA; m_hresp = HRESP;
                end
            end else if (m_held && !w_stall_i) begin
                m_held = 0;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic to_neg; @(negedge clk_i); #1; endtask
    task automatic to_pos; @(posedge clk_i); #1; endtask

    task automatic insn(input logic ld, input logic st, input logic [2:0] fun,
                        input logic [4:0] rd, input logic rdw, input logic [1:0] src,
                        input logic [31:0] addr);
        x_valid_i = 1; x_load_i = ld; x_store_i = st; x_fun_i = fun;
        x_rd_i = rd; x_rd_write_i = rdw; x_rd_source_i = src; x_dm_addr_i = addr;
    endtask

    task automatic idle;
        x_valid_i = 0; x_load_i = 0; x_store_i = 0; x_rd_write_i = 0;
    endtask

    initial begin
        rst_i = 0; w_stall_i = 0; idle();
        x_fun_i = 0; x_rd_i = 0; x_rd_value_i = 0; x_rd_source_i = 0;
        x_shifter_rd_value_i = 0; x_multiply_rd_value_i = 0; x_dm_addr_i = 0;
        HRDATA = 0; HREADY = 1; HRESP = 0;

        // reset: write port forced low even with a writing instruction present
        to_pos;
        insn(0, 0, 3'd0, 5'd3, 1, 2'd0, 0); x_rd_value_i = 32'h1111;
        to_neg;
        chk("reset_rf_write", rf_rd_write_o, 1'b0);
        chk("reset_bus_error", w_bus_error_o, 1'b0);
        chk("reset_byp_write", w_bypass_rd_write_o, 1'b0);
        chk("reset_byp_value", w_bypass_rd_value_o, 32'h0);

        // LB off 3
        to_pos; rst_i = 1;
        insn(1, 0, 3'd0, 5'd1, 1, 2'd0, 32'h1003); HRDATA = 32'h80123456; HREADY = 1;
        to_neg;
        chk("lb_value", rf_rd_value_o, 32'hFFFFFF80);
        chk("lb_write", rf_rd_write_o, 1'b1);

        // LHU / LH off 2
        to_pos;
        insn(1, 0, 3'd5, 5'd2, 1, 2'd0, 32'h2002); HRDATA = 32'hBEEF1234;
        to_neg;
        chk("lhu_value", rf_rd_value_o, 32'h0000BEEF);
        chk("lb_bypass_rd", w_bypass_rd_o, 5'd1);
        chk("lb_bypass_value", w_bypass_rd_value_o, 32'hFFFFFF80);
        to_pos;
        insn(1, 0, 3'd1, 5'd2, 1, 2'd0, 32'h2002);
        to_neg;
        chk("lh_value", rf_rd_value_o, 32'hFFFFBEEF);

        // LBU off 1
        to_pos;
        insn(1, 0, 3'd4, 5'd4, 1, 2'd0, 32'h0001); HRDATA = 32'h4433A211;
        to_neg;
        chk("lbu_value", rf_rd_value_o, 32'h000000A2);

        // LW with two wait states
        to_pos;
        insn(1, 0, 3'd2, 5'd7, 1, 2'd0, 0); HRDATA = 32'hCAFEF00D; HREADY = 0;
        to_neg;
        chk("lw_wait1_stall", w_stall_req_o, 1'b1);
        chk("lw_wait1_write", rf_rd_write_o, 1'b0);
        to_pos; to_neg;
        chk("lw_wait2_stall", w_stall_req_o, 1'b1);
        to_pos; HREADY = 1;
        to_neg;
        chk("lw_done_write", rf_rd_write_o, 1'b1);
        chk("lw_done_value", rf_rd_value_o, 32'hCAFEF00D);
        chk("lw_done_stall", w_stall_req_o, 1'b0);

        // LW completing under stall: captured data used later
        to_pos;
        insn(1, 0, 3'd2, 5'd8, 1, 2'd0, 0); HRDATA = 32'h12345678; HREADY = 1; w_stall_i = 1;
        to_neg;
        chk("held_cap_write", rf_rd_write_o, 1'b0);
        to_pos; HRDATA = 0; HREADY = 0;
        to_neg;
        chk("held_stall_req", w_stall_req_o, 1'b0);
        to_pos; w_stall_i = 0;
        to_neg;
        chk("held_write", rf_rd_write_o, 1'b1);
        chk("held_value", rf_rd_value_o, 32'h12345678);

        // shifter source, x0 then x5
        to_pos; HREADY = 1;
        insn(0, 0, 3'd0, 5'd0, 1, 2'd1, 0); x_shifter_rd_value_i = 32'h10;
        to_neg;
        chk("x0_write", rf_rd_write_o, 1'b0);
        to_pos; x_rd_i = 5'd5;
        to_neg;
        chk("x5_write", rf_rd_write_o, 1'b1);
        chk("x5_value", rf_rd_value_o, 32'h10);
        to_pos; idle();
        to_neg;
        chk("x5_bypass_rd", w_bypass_rd_o, 5'd5);
        chk("x5_bypass_value", w_bypass_rd_value_o, 32'h10);
        chk("x5_bypass_write", w_bypass_rd_write_o, 1'b1);

        // multiply source held by stall one cycle
        to_pos;
        insn(0, 0, 3'd0, 5'd6, 1, 2'd2, 0); x_multiply_rd_value_i = 32'hDEADBEEF; w_stall_i = 1;
        to_neg;
        chk("mul_stalled_write", rf_rd_write_o, 1'b0);
        to_pos; w_stall_i = 0;
        to_neg;
        chk("mul_value", rf_rd_value_o, 32'hDEADBEEF);

        // CSR source
        to_pos;
        insn(0, 0, 3'd0, 5'd10, 1, 2'd3, 0); x_rd_value_i = 32'h00001234;
        to_neg;
        chk("csr_value", rf_rd_value_o, 32'h00001234);

        // store with one wait state
        to_pos;
        insn(0, 1, 3'd2, 5'd11, 0, 2'd0, 0); HREADY = 0;
        to_neg;
        chk("st_wait_stall", w_stall_req_o, 1'b1);
        to_pos; HREADY = 1;
        to_neg;
        chk("st_done_write", rf_rd_write_o, 1'b0);
        chk("st_done_stall", w_stall_req_o, 1'b0);

        // LW with error response
        to_pos;
        insn(1, 0, 3'd2, 5'd9, 1, 2'd0, 0); HRDATA = 32'hFFFFFFFF; HRESP = 1;
        to_neg;
        chk("err_write", rf_rd_write_o, 1'b0);
        chk("err_flag_same_cycle", w_bus_error_o, 1'b0);
        to_pos; idle(); HRESP = 0;
        to_neg;
        chk("err_flag_next", w_bus_error_o, 1'b1);
        repeat (3) to_pos;
        to_neg;
        chk("err_flag_sticky", w_bus_error_o, 1'b1);

        // reset while waiting abandons the load
        to_pos;
        insn(1, 0, 3'd2, 5'd12, 1, 2'd0, 0); HREADY = 0;
        to_neg;
        chk("rst_wait_stall", w_stall_req_o, 1'b1);
        to_pos; rst_i = 0;
        to_neg;
        chk("rst_wait_write", rf_rd_write_o, 1'b0);
        to_pos; rst_i = 1; idle(); HREADY = 1;
        to_neg;
        chk("rst_err_clear", w_bus_error_o, 1'b0);
        chk("rst_byp_clear", w_bypass_rd_write_o, 1'b0);

        to_pos;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/kmkz_writeback.md
# kmkz_writeback

Writeback stage of the Kamikaze-uRV pipeline, directly downstream of the execute stage. Consumes the execute stage's registered X/W outputs, completes the AHB-Lite data phase for loads and stores, aligns and sign-extends load data, selects the destination value (ALU/CSR, shifter, multiplier or load), and drives the register-file write port. Also provides a one-entry registered bypass of the last retired write, a stall request for wait-stated data phases, and a sticky bus-error flag.

## Interface
Parameters:
- none

Ports:
- clk_i  in  1  core clock; single clock domain
- rst_i  in  1  synchronous, active-low reset
- w_stall_i  in  1  pipeline stall from control; no retirement while high
- w_stall_req_o  out  1  stall request while a data phase is wait-stated
- x_fun_i  in  3  funct3 of instruction (load size/sign)
- x_load_i, x_store_i  in  1  instruction is a load / store (exec-qualified)
- x_valid_i  in  1  instruction in this stage is valid
- x_rd_i  in  5  destination register index
- x_rd_write_i  in  1  instruction writes rd
- x_rd_value_i  in  32  ALU/CSR result
- x_rd_source_i  in  2  result source select
- x_shifter_rd_value_i, x_multiply_rd_value_i  in  32  shifter / multiplier results
- x_dm_addr_i  in  32  load/store byte address (only [1:0] used)
- HRDATA  in  32  AHB read data
- HREADY  in  1  AHB data phase complete
- HRESP  in  1  AHB error response
- rf_rd_o  out  5  register-file write index
- rf_rd_value_o  out  32  register-file write data
- rf_rd_write_o  out  1  register-file write enable
- w_bypass_rd_o, w_bypass_rd_value_o, w_bypass_rd_write_o  out  5/32/1  registered copy of last retired write
- w_bus_error_o  out  1  sticky: a data phase returned HRESP=1

## Operation
- mem = (x_load_i | x_store_i) & x_valid_i.
- FSM states: IDLE, WAIT, HELD.
  - IDLE: non-mem instruction retires when !w_stall_i. Mem: HREADY=1 & !w_stall_i → retire, stay IDLE; HREADY=1 & w_stall_i → capture HRDATA/HRESP, go HELD; HREADY=0 → WAIT.
  - WAIT: HREADY=1 → same as IDLE's HREADY=1 branches; HREADY=0 → stay.
  - HELD: HRDATA/HREADY ignored; captured data used; !w_stall_i → retire, go IDLE.
- w_stall_req_o = mem & !HREADY & state≠HELD (combinational).
- Retire cycle: rf_rd_write_o = x_rd_write_i & x_valid_i & (x_rd_i≠0) & !err, where err = HRESP (or captured HRESP) on a load; otherwise 0.
- Value select: load → aligned load data; else source ALU/CSR → x_rd_value_i, SHIFTER → x_shifter_rd_value_i, MULTIPLY → x_multiply_rd_value_i.
- Load alignment, off = x_dm_addr_i[1:0]: B/BU take byte lane off; H/HU take halfword lane off[1]; L full word; B/H sign-extend, BU/HU zero-extend. Alignment is not checked (addresses assumed legal by exec).
- Store: no rd write; occupies stage until data phase completes; HRESP=1 sets error flag only.
- w_bus_error_o set on any completed data phase with HRESP=1; cleared only by reset.
- Bypass registers load rf_rd_* on every retire cycle; hold otherwise.

## Timing
- Exec issues the address phase in cycle N; this block sees the instruction in N+1 (data phase). Zero-wait load: rf write combinational in N+1, bypass valid in N+2.
- k wait states: w_stall_req_o high k cycles, write in cycle N+1+k.
- Reset (rst_i=0 at edge): state IDLE, bypass outputs 0, w_bus_error_o 0, captured data 0; combinational outputs follow inputs but rf_rd_write_o forced 0 while rst_i=0. Reset mid-WAIT/HELD abandons the instruction (no write).
- HRESP and HREADY both high on a load: no rd write, error set that cycle+1.

## Structure
- Shared package/defines (kmkz_defs.v): LDST_B=0, LDST_H=1, LDST_L=2, LDST_BU=4, LDST_HU=5; RD_SOURCE_ALU=0, RD_SOURCE_SHIFTER=1, RD_SOURCE_MULTIPLY=2, RD_SOURCE_CSR=3; FSM state encodings.
- One sub-module: kmkz_load_align (combinational lane select + extend).

## Test plan
- LB, addr[1:0]=3, HRDATA=0x80123456, HREADY=1 → rf_rd_value_o=0xFFFFFF80, write same cycle.
- LHU, addr[1:0]=2, HRDATA=0xBEEF1234 → 0x0000BEEF; LH same → 0xFFFFBEEF.
- LW with HREADY low 2 cycles, HRDATA=0xCAFEF00D → w_stall_req_o high 2 cycles, write in 3rd.
- LW, HREADY=1 with w_stall_i=1 for 2 cycles, HRDATA changed to 0 meanwhile → HELD, writes 0x... original value after stall drops.
- LW with HRESP=1 → no write, w_bus_error_o=1 next cycle, stays 1 until reset.
- Shifter source, rd=x0 then rd=x5, value 0x00000010 → first no write, second writes x5, bypass shows x5/0x10 next cycle.
